lvds_link_trainer: RTL and testbench

LVDS_LINK_TRAINER -- requirements
Module: lvds_link_trainer

---
 rtl/link_pkg.sv | 25 ++
 rtl/lane_aligner.sv | 146 ++++++++++++++
 rtl/lvds_link_trainer.sv | 58 +++++
 tb/tb_lvds_link_trainer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_pkg
// Description : Shared lane-state encoding and lane word selection helper
//               for the LVDS link trainer.
// Revision    : 1.0 - initial release
// ============================================================================
package link_pkg;

    typedef enum logic [2:0] {
        LS_IDLE   = 3'd0,
        LS_CHECK  = 3'd1,
        LS_SLIP   = 3'd2,
        LS_HOLD   = 3'd3,
        LS_LOCKED = 3'd4,
        LS_FAIL   = 3'd5
    } lane_state_t;

    // Bit offset of a lane's word inside the packed multi-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_aligner.sv
`default_nettype none
// ============================================================================
// Module      : lane_aligner
// Description : Single-lane word aligner: bitslips until the training word is
//               seen STABLE_CYCLES times in a row, then monitors for loss.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_aligner
    import link_pkg::*;
#(
    parameter int unsigned              SERIALIZATION = 8,
    parameter logic [SERIALIZATION-1:0] SYNC_PATTERN  = SERIALIZATION'(8'hF0),
    parameter int unsigned              STABLE_CYCLES = 16,
    parameter int unsigned              SLIP_HOLDOFF  = 4,
    parameter int unsigned              MAX_SLIPS     = 2 * SERIALIZATION,
    parameter int unsigned              LOSS_CYCLES   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_train,
    input  logic                     i_monitor,
    input  logic [SERIALIZATION-1:0] i_word,
    output logic                     o_slip_pulse,
    output logic                     o_locked,
    output logic                     o_fail,
    output logic                     o_lock_lost
);

    localparam int unsigned c_stable_w = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned c_slip_w   = $clog2(MAX_SLIPS + 1);
    localparam int unsigned c_hold_w   = $clog2(SLIP_HOLDOFF + 1);
    localparam int unsigned c_loss_w   = $clog2(LOSS_CYCLES + 1);

    localparam logic [c_stable_w-1:0] c_stable_last = c_stable_w'(STABLE_CYCLES - 1);
    localparam logic [c_stable_w-1:0] c_stable_max  = c_stable_w'(STABLE_CYCLES);
    localparam logic [c_stable_w-1:0] c_stable_one  = c_stable_w'(1);
    localparam logic [c_slip_w-1:0]   c_slip_max    = c_slip_w'(MAX_SLIPS);
    localparam logic [c_slip_w-1:0]   c_slip_one    = c_slip_w'(1);
    localparam logic [c_hold_w-1:0]   c_hold_last   = c_hold_w'(SLIP_HOLDOFF - 1);
    localparam logic [c_hold_w-1:0]   c_hold_one    = c_hold_w'(1);
    localparam logic [c_loss_w-1:0]   c_loss_last   = c_loss_w'(LOSS_CYCLES - 1);
    localparam logic [c_loss_w-1:0]   c_loss_one    = c_loss_w'(1);

    lane_state_t           r_state,      w_state;
    logic [c_stable_w-1:0] r_stable_cnt, w_stable_cnt;
    logic [c_slip_w-1:0]   r_slip_cnt,   w_slip_cnt;
    logic [c_hold_w-1:0]   r_hold_cnt,   w_hold_cnt;
    logic [c_loss_w-1:0]   r_loss_cnt,   w_loss_cnt;
    logic                  r_lock_lost,  w_lock_lost;
    logic                  w_match;

    assign w_match = (i_word == SYNC_PATTERN);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= LS_IDLE;
            r_stable_cnt <= '0;
            r_slip_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_loss_cnt   <= '0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_stable_cnt <= w_stable_cnt;
            r_slip_cnt   <= w_slip_cnt;
            r_hold_cnt   <= w_hold_cnt;
            r_loss_cnt   <= w_loss_cnt;
            r_lock_lost  <= w_lock_lost;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_stable_cnt = r_stable_cnt;
        w_slip_cnt   = r_slip_cnt;
        w_hold_cnt   = r_hold_cnt;
        w_loss_cnt   = r_loss_cnt;
        w_lock_lost  = 1'b0;
        // Training restart overrides everything, including a loss event.
        if (i_train) begin
            w_state      = LS_CHECK;
            w_stable_cnt = '0;
            w_slip_cnt   = '0;
            w_hold_cnt   = '0;
            w_loss_cnt   = '0;
        end else begin
            case (r_state)
                LS_IDLE: ;
                LS_CHECK: begin
                    if (w_match) begin
                        if (r_stable_cnt == c_stable_last) begin
                            w_state      = LS_LOCKED;
                            w_stable_cnt = c_stable_max;
                            w_loss_cnt   = '0;
                        end else begin
                            w_stable_cnt = r_stable_cnt + c_stable_one;
                        end
                    end else begin
                        w_stable_cnt = '0;
                        w_state      = (r_slip_cnt == c_slip_max) ? LS_FAIL : LS_SLIP;
                    end
                end
                LS_SLIP: begin
                    if (r_slip_cnt != c_slip_max) begin
                        w_slip_cnt = r_slip_cnt + c_slip_one;
                    end
                    w_hold_cnt = '0;
                    w_state    = LS_HOLD;
                end
                LS_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        w_hold_cnt = '0;
                        w_state    = LS_CHECK;
                    end else begin
                        w_hold_cnt = r_hold_cnt + c_hold_one;
                    end
                end
                LS_LOCKED: begin
                    if (i_monitor && !w_match) begin
                        if (r_loss_cnt == c_loss_last) begin
                            w_state      = LS_CHECK;
                            w_stable_cnt = '0;
                            w_slip_cnt   = '0;
                            w_hold_cnt   = '0;
                            w_loss_cnt   = '0;
                            w_lock_lost  = 1'b1;
                        end else begin
                            w_loss_cnt = r_loss_cnt + c_loss_one;
                        end
                    end else begin
                        w_loss_cnt = '0;
                    end
                end
                LS_FAIL: ;
                default: w_state = LS_IDLE;
            endcase
        end
    end

    assign o_slip_pulse = (r_state == LS_SLIP);
    assign o_locked     = (r_state == LS_LOCKED);
    assign o_fail       = (r_state == LS_FAIL);
    assign o_lock_lost  = r_lock_lost;

endmodule
`default_nettype wire

// File: rtl/lvds_link_trainer.sv
`default_nettype none
// ============================================================================
// Module      : lvds_link_trainer
// Description : Multi-lane LVDS receive word-alignment trainer; one aligner
//               per lane plus link-level ready / lock-lost status.
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_link_trainer
    import link_pkg::*;
#(
    parameter int unsigned              SERIALIZATION = 8,
    parameter int unsigned              CHANNELS      = 4,
    parameter logic [SERIALIZATION-1:0] SYNC_PATTERN  = SERIALIZATION'(8'hF0),
    parameter int unsigned              STABLE_CYCLES = 16,
    parameter int unsigned              SLIP_HOLDOFF  = 4,
    parameter int unsigned              MAX_SLIPS     = 2 * SERIALIZATION,
    parameter int unsigned              LOSS_CYCLES   = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_train,
    input  logic                              i_monitor,
    input  logic [SERIALIZATION*CHANNELS-1:0] i_data,
    output logic [CHANNELS-1:0]               o_slip_pulse,
    output logic [CHANNELS-1:0]               o_lane_locked,
    output logic [CHANNELS-1:0]               o_lane_fail,
    output logic                              o_lock_lost,
    output logic                              o_ready
);

    logic [CHANNELS-1:0] w_lock_lost;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        lane_aligner #(
            .SERIALIZATION (SERIALIZATION),
            .SYNC_PATTERN  (SYNC_PATTERN),
            .STABLE_CYCLES (STABLE_CYCLES),
            .SLIP_HOLDOFF  (SLIP_HOLDOFF),
            .MAX_SLIPS     (MAX_SLIPS),
            .LOSS_CYCLES   (LOSS_CYCLES)
        ) u_lane (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_train      (i_train),
            .i_monitor    (i_monitor),
            .i_word       (i_data[lane_lsb(k, SERIALIZATION) +: SERIALIZATION]),
            .o_slip_pulse (o_slip_pulse[k]),
            .o_locked     (o_lane_locked[k]),
            .o_fail       (o_lane_fail[k]),
            .o_lock_lost  (w_lock_lost[k])
        );
    end

    assign o_lock_lost = |w_lock_lost;
    assign o_ready     = &o_lane_locked;

endmodule
`default_nettype wire

// File: tb/tb_lvds_link_trainer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvds_link_trainer
// Description : Scoreboard bench for lvds_link_trainer with a bitslip-aware
//               deserialiser model driving each lane.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_link_trainer;

    localparam int         SER     = 8;
    localparam int         CH      = 4;
    localparam int         STABLE  = 16;
    localparam int         HOLDOFF = 4;
    localparam int         MAXS    = 16;
    localparam int         LOSS    = 8;
    localparam logic [7:0] SYNC    = 8'hF0;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b1;
    logic              train   = 1'b0;
    logic              monitor = 1'b0;
    logic [SER*CH-1:0] data    = '0;
    logic [CH-1:0]     slip, locked, fail;
    logic              lost, ready;

    always #5 clk = ~clk;

    lvds_link_trainer #(
        .SERIALIZATION (SER),
        .CHANNELS      (CH),
        .SYNC_PATTERN  (SYNC),
        .STABLE_CYCLES (STABLE),
        .SLIP_HOLDOFF  (HOLDOFF),
        .MAX_SLIPS     (MAXS),
        .LOSS_CYCLES   (LOSS)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_train       (train),
        .i_monitor     (monitor),
        .i_data        (data),
        .o_slip_pulse  (slip),
        .o_lane_locked (locked),
        .o_lane_fail   (fail),
        .o_lock_lost   (lost),
        .o_ready       (ready)
    );

    // Deserialiser model: each lane shows its pattern rotated by rot[k];
    // every slip pulse moves the rotation one step toward alignment.
    logic [7:0]  pat [CH];
    int          rot [CH];
    int          slips [CH];
    int          last_slip [CH];
    int          min_gap [CH];
    int          cyc, ready_cyc, lost_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    string       tag_q [$];
    logic [31:0] exp_q [$];

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic compare_next(input logic [31:0] obs);
        if (exp_q.size() == 0) check_val("sb_empty", 32'(exp_q.size()), 32'd1);
        else check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    task automatic drive_data();
        for (int k = 0; k < CH; k++) data[k*SER +: SER] = rotl(pat[k], rot[k]);
    endtask

    task automatic clear_stats();
        for (int k = 0; k < CH; k++) begin
            slips[k] = 0; last_slip[k] = -1000; min_gap[k] = 1000;
        end
        cyc = 0; ready_cyc = -1; lost_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < CH; k++) begin
            if (slip[k]) begin
                slips[k]++;
                if (cyc - last_slip[k] < min_gap[k]) min_gap[k] = cyc - last_slip[k];
                last_slip[k] = cyc;
                rot[k] = (rot[k] + 7) % 8;
            end
        end
        if (ready && ready_cyc < 0) ready_cyc = cyc;
        if (lost) lost_cnt++;
        drive_data();
    endtask

    task automatic pulse_train();
        clear_stats();
        train = 1'b1;
        tick();
        train = 1'b0;
    endtask

    task automatic run_until_ready(input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
    endtask

    function automatic int sum_slips();
        int s;
        s = 0;
        for (int k = 0; k < CH; k++) s += slips[k];
        return s;
    endfunction

    initial begin
        for (int k = 0; k < CH; k++) begin pat[k] = SYNC; rot[k] = 0; end
        clear_stats();
        drive_data();
        #1 rst_n = 1'b0;
        repeat (3) tick();

        // Reset state
        push_exp("rst_locked", 0); push_exp("rst_fail", 0); push_exp("rst_slip", 0);
        push_exp("rst_ready", 0);  push_exp("rst_lost", 0);
        compare_next(32'(locked)); compare_next(32'(fail)); compare_next(32'(slip));
        compare_next(32'(ready));  compare_next(32'(lost));

        // No activity after reset until a training pulse
        rst_n = 1'b1;
        clear_stats();
        push_exp("idle_locked", 0); push_exp("idle_slips", 0);
        repeat (20) tick();
        compare_next(32'(locked)); compare_next(32'(sum_slips()));

        // Aligned link: ready exactly at cycle 1+STABLE_CYCLES
        push_exp("aligned_c16_ready", 0); push_exp("aligned_ready_cyc", 17); push_exp("aligned_slips", 0);
        pulse_train();
        repeat (15) tick();
        compare_next(32'(ready));
        run_until_ready(100);
        compare_next(32'(ready_cyc)); compare_next(32'(sum_slips()));

        // Lane 2 rotated by 3: three slips, six cycles apart, lock at 35
        rot[2] = 3;
        drive_data();
        push_exp("rot3_slips2", 3); push_exp("rot3_gap_ok", 1); push_exp("rot3_other_slips", 0);
        push_exp("rot3_ready_cyc", 35);
        pulse_train();
        run_until_ready(200);
        compare_next(32'(slips[2])); compare_next(32'(min_gap[2] >= HOLDOFF + 1));
        compare_next(32'(slips[0] + slips[1] + slips[3])); compare_next(32'(ready_cyc));

        // Lane 1 never aligns: slip budget exhausted, sticky fail
        for (int k = 0; k < CH; k++) rot[k] = 0;
        pat[1] = 8'h00;
        drive_data();
        push_exp("dead_slips1", 16); push_exp("dead_fail", 4'b0010);
        push_exp("dead_locked", 4'b1101); push_exp("dead_ready", 0);
        pulse_train();
        repeat (150) tick();
        compare_next(32'(slips[1])); compare_next(32'(fail));
        compare_next(32'(locked));   compare_next(32'(ready));

        // Retrain clears fail; then loss behaviour with and without monitor
        pat[1] = SYNC;
        drive_data();
        push_exp("retrain_ready_cyc", 17); push_exp("retrain_fail", 0);
        pulse_train();
        run_until_ready(100);
        compare_next(32'(ready_cyc)); compare_next(32'(fail));

        push_exp("nomon_lost", 0); push_exp("nomon_locked", 4'hF);
        pat[0] = 8'h00;
        drive_data();
        repeat (10) tick();
        compare_next(32'(lost_cnt)); compare_next(32'(locked));

        pat[0] = SYNC;
        drive_data();
        tick();
        monitor = 1'b1;
        clear_stats();
        push_exp("loss_c7_locked", 4'hF); push_exp("loss_c8_lost", 1);
        push_exp("loss_c8_locked", 4'b1110);
        pat[0] = 8'h00;
        drive_data();
        repeat (7) tick();
        compare_next(32'(locked));
        tick();
        compare_next(32'(lost)); compare_next(32'(locked));

        push_exp("relock_ready", 1); push_exp("relock_slips0", 2); push_exp("relock_lost_pulses", 1);
        pat[0] = SYNC;
        rot[0] = 2;
        drive_data();
        run_until_ready(200);
        compare_next(32'(ready)); compare_next(32'(slips[0])); compare_next(32'(lost_cnt));

        // Asynchronous reset while lane 2 sits in HOLD
        monitor = 1'b0;
        rot[0] = 0;
        rot[2] = 4;
        drive_data();
        push_exp("hold_slips2", 4); push_exp("hold_locked", 4'b1011);
        pulse_train();
        repeat (21) tick();
        compare_next(32'(slips[2])); compare_next(32'(locked));

        push_exp("arst_outputs", 0);
        #2 rst_n = 1'b0;
        #1 compare_next(32'({slip, locked, fail, lost, ready}));
        #2 rst_n = 1'b1;
        clear_stats();
        push_exp("post_rst_slips", 0); push_exp("post_rst_locked", 0);
        repeat (30) tick();
        compare_next(32'(sum_slips())); compare_next(32'(locked));

        check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
